mem_boot_arbiter: RTL and testbench
===================================

// Module: mem_boot_arbiter
// PURPOSE
//  Owns the single instruction/data memory port of top_core; shares it between the SPI loader and the core.
//  Sequences boot: the SPI loader fills memory from BOOT_ADDR; writing END_WORD arms the core.
//  fetch_enable_i then releases the core. Sits between the SPI slave, the core LSU/IF mux and the SRAM wrapper.
// PARAMETERS
//  ADDR_W        32            address width, all ports
//  DATA_W        32            data width, all ports
//  END_WORD      32'h00000FFF  SPI write data that terminates program load
//  TIMEOUT_CYC   4096          LOAD idle-cycle limit (BOOT_TIMEOUT_EN only)
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       asynchronous, active-high reset
//  fetch_enable_i in   1       external run request
//  spi_req_i      in   1       SPI request; held until spi_gnt_o
//  spi_we_i       in   1       1=write
//  spi_addr_i     in   ADDR_W  SPI byte address
//  spi_wdata_i    in   DATA_W  SPI write data
//  spi_gnt_o      out  1       SPI request accepted this cycle
//  spi_rvalid_o   out  1       SPI read data valid
//  spi_rdata_o    out  DATA_W  SPI read data
//  core_req_i/core_we_i/core_addr_i/core_wdata_i  in  1/1/ADDR_W/DATA_W  core request, same semantics
//  core_gnt_o/core_rvalid_o/core_rdata_o          out 1/1/DATA_W         core response
//  mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o      out 1/1/ADDR_W/DATA_W  memory request
//  mem_gnt_i/mem_rvalid_i/mem_rdata_i             in  1/1/DATA_W         memory response
//  fetch_enable_o out  1       core fetch enable
//  state_o        out  2       FSM state (boot_pkg::state_e)
//  timeout_o      out  1       sticky load-timeout flag
// BEHAVIOUR
//  Reset: state=LOAD; all *_gnt_o, *_rvalid_o, mem_req_o, fetch_enable_o, timeout_o = 0; rdata = 0; rr_ptr=SPI.
//  FSM:
//   LOAD : only SPI may be granted; core_gnt_o=0.
//          Granted SPI write with wdata==END_WORD -> ARMED (the write itself completes).
//   ARMED: SPI still serviced. fetch_enable_i=1 -> RUN. fetch_enable_i high on the END_WORD cycle reaches RUN no earlier than the following cycle.
//   RUN  : fetch_enable_o=1 (registered, asserted first cycle in RUN). Both ports eligible.
//          fetch_enable_i=0 -> DRAIN; fetch_enable_o drops that same edge.
//   DRAIN: no new core grants; SPI eligible. Outstanding core read count==0 -> ARMED.
//  Arbitration: combinational grant path req->mem_req_o.
//   Grant = mem_gnt_i & selected req, same cycle. One requester per cycle.
//   Round-robin when both are eligible; rr_ptr flips to the other port after each grant.
//  Read return: mem returns in order. 2-entry owner FIFO pushed on granted read, popped on mem_rvalid_i.
//   Popped owner routes rvalid/rdata; rdata held until next rvalid.
//   FIFO full -> no read grants (writes still allowed). Push+pop same cycle is legal at full.
//  Writes produce no rvalid.
//  Reset mid-transaction: all state cleared; an in-flight rvalid after reset is discarded (FIFO empty).
// CONFIGURATION
//  BOOT_TIMEOUT_EN defined:
//   - Idle counter runs in LOAD; clears on each SPI grant.
//   - Reaching TIMEOUT_CYC-1 -> ARMED and timeout_o=1 (sticky until reset).
//  Not defined: no counter; timeout_o tied 0; LOAD exits only on END_WORD.
// STRUCTURE
//  boot_pkg: state_e {LOAD,ARMED,RUN,DRAIN}, owner_e {OWN_SPI,OWN_CORE}, END_WORD default const.
//  Sub-module rsp_owner_fifo (depth 2, width 1, push/pop/full/empty); FSM and arbiter inline.
// TESTING
//  1 Reset, SPI writes 0x80..0x8C then END_WORD@0x90, mem_gnt_i=1
//    -> 5 spi_gnt_o pulses; state LOAD->ARMED after 5th; fetch_enable_o=0.
//  2 In LOAD, core_req_i=1 for 20 cycles -> core_gnt_o never 1.
//    fetch_enable_i=1 in ARMED -> fetch_enable_o=1 next cycle.
//  3 RUN, spi and core reads both held, mem_gnt_i=1, rvalid 1 cycle later
//    -> grants alternate SPI/CORE; each rdata reaches correct port only.
//  4 RUN, three back-to-back core reads, rvalid withheld -> 3rd stalls (FIFO full) until 1st rvalid.
//  5 RUN, 2 reads outstanding, fetch_enable_i=0 -> DRAIN, fetch_enable_o=0; ARMED after 2nd rvalid.
//  6 BOOT_TIMEOUT_EN, TIMEOUT_CYC=16, no SPI traffic
//    -> ARMED, timeout_o=1 at cycle 16. rst_i pulse mid-read -> outputs zero, stale rvalid ignored.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time memory port arbiter.
package boot_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_CORE = 1'b1
  } owner_e;

  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/rsp_owner_fifo.sv
// Small in-order FIFO remembering which requester owns each outstanding read.
module rsp_owner_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] storage_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees a slot in the same cycle, so push is accepted at full alongside it.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = storage_q[rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) storage_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mem_boot_arbiter.sv
// Shares one memory port between the SPI loader and the core and sequences boot.
// Optional load-idle timeout is enabled by defining BOOT_TIMEOUT_EN.
module mem_boot_arbiter
  import boot_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [DATA_W-1:0] END_WORD    = DATA_W'(END_WORD_DEFAULT),
  parameter int unsigned       TIMEOUT_CYC = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_enable_i,
  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  output logic              spi_gnt_o,
  output logic              spi_rvalid_o,
  output logic [DATA_W-1:0] spi_rdata_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              fetch_enable_o,
  output state_e            state_o,
  output logic              timeout_o
);

  state_e            state_q, state_d;
  owner_e            rr_q, rr_d, head_owner;
  logic [1:0]        core_out_q, core_out_d;
  logic              fetch_en_q;
  logic              spi_rvalid_q, core_rvalid_q;
  logic [DATA_W-1:0] spi_rdata_q, core_rdata_q;
  logic              spi_elig, core_elig, sel_core, granted;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, timeout_hit;
  logic [0:0]        fifo_head;

  // Reads need a free owner slot; writes never return data so they bypass it.
  assign spi_elig  = ~rst_i & spi_req_i & (spi_we_i | ~fifo_full);
  assign core_elig = ~rst_i & (state_q == RUN) & core_req_i & (core_we_i | ~fifo_full);
  assign sel_core  = core_elig & (~spi_elig | (rr_q == OWN_CORE));

  assign mem_req_o   = spi_elig | core_elig;
  assign mem_we_o    = mem_req_o & (sel_core ? core_we_i : spi_we_i);
  assign mem_addr_o  = mem_req_o ? (sel_core ? core_addr_i : spi_addr_i) : '0;
  assign mem_wdata_o = mem_req_o ? (sel_core ? core_wdata_i : spi_wdata_i) : '0;
  assign spi_gnt_o   = spi_elig & ~sel_core & mem_gnt_i;
  assign core_gnt_o  = sel_core & mem_gnt_i;
  assign granted     = spi_gnt_o | core_gnt_o;

  assign fifo_push  = granted & ~mem_we_o;
  assign fifo_pop   = mem_rvalid_i & ~fifo_empty;
  assign head_owner = owner_e'(fifo_head);
  assign rr_d       = granted ? (sel_core ? OWN_SPI : OWN_CORE) : rr_q;

  rsp_owner_fifo #(
    .Depth (2),
    .Width (1)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (sel_core),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    core_out_d = core_out_q;
    if (core_gnt_o && !core_we_i)              core_out_d = core_out_d + 2'd1;
    if (fifo_pop && (head_owner == OWN_CORE)) core_out_d = core_out_d - 2'd1;
  end

`ifdef BOOT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

  logic [CntW-1:0] idle_q, idle_d;
  logic            timeout_q;

  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (state_q == LOAD) begin
      if (spi_gnt_o)                             idle_d = '0;
      else if (idle_q == CntW'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
      else                                       idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if ((spi_gnt_o && spi_we_i && (spi_wdata_i == END_WORD)) || timeout_hit) state_d = ARMED;
      end
      ARMED:   if (fetch_enable_i)      state_d = RUN;
      RUN:     if (!fetch_enable_i)     state_d = DRAIN;
      DRAIN:   if (core_out_q == 2'd0)  state_d = ARMED;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= LOAD;
      rr_q          <= OWN_SPI;
      core_out_q    <= 2'd0;
      fetch_en_q    <= 1'b0;
      spi_rvalid_q  <= 1'b0;
      core_rvalid_q <= 1'b0;
      spi_rdata_q   <= '0;
      core_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      core_out_q    <= core_out_d;
      fetch_en_q    <= (state_d == RUN);
      spi_rvalid_q  <= fifo_pop & (head_owner == OWN_SPI);
      core_rvalid_q <= fifo_pop & (head_owner == OWN_CORE);
      if (fifo_pop && (head_owner == OWN_SPI))  spi_rdata_q  <= mem_rdata_i;
      if (fifo_pop && (head_owner == OWN_CORE)) core_rdata_q <= mem_rdata_i;
    end
  end

  assign state_o        = state_q;
  assign fetch_enable_o = fetch_en_q;
  assign spi_rvalid_o   = spi_rvalid_q;
  assign core_rvalid_o  = core_rvalid_q;
  assign spi_rdata_o    = spi_rdata_q;
  assign core_rdata_o   = core_rdata_q;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Self-checking bench for mem_boot_arbiter: boot vector table, directed corner cases, random run.
module tb_mem_boot_arbiter;
  import boot_pkg::*;

  localparam logic [31:0] END = 32'h0000_0FFF;
  localparam int          TO  = 16;

  logic        clk = 1'b0, rst = 1'b0, fe = 1'b0;
  logic        spi_req = 0, spi_we = 0, core_req = 0, core_we = 0;
  logic [31:0] spi_addr = 0, spi_wdata = 0, core_addr = 0, core_wdata = 0;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        spi_gnt, spi_rv, core_gnt, core_rv, mem_req, mem_we, fe_o, to_o;
  logic [31:0] spi_rd, core_rd, mem_addr, mem_wdata;
  state_e      st_o;

  int checks = 0, failures = 0;
  int rv_mode = 0;  // 0: withhold rvalid, 1: return one cycle after grant, 2: random delay

  // Reference model: spec-level state, rr preference, in-order owner list, memory.
  state_e      m_state;
  bit          m_rr_core, m_spi_rv, m_core_rv, m_to;
  logic [31:0] m_spi_rd, m_core_rd;
  int          m_idle;
  bit          m_own[$];
  logic [31:0] pend[$];
  logic [31:0] mem_arr[64];

  // Values sampled at the last checked negedge.
  bit          s_spi_gnt, s_core_gnt, s_fe, s_to, s_spi_rv, s_core_rv;
  state_e      s_state;
  logic [31:0] s_spi_rd, s_core_rd;

  always #5 clk = ~clk;

  mem_boot_arbiter #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fe),
    .spi_req_i      (spi_req),
    .spi_we_i       (spi_we),
    .spi_addr_i     (spi_addr),
    .spi_wdata_i    (spi_wdata),
    .spi_gnt_o      (spi_gnt),
    .spi_rvalid_o   (spi_rv),
    .spi_rdata_o    (spi_rd),
    .core_req_i     (core_req),
    .core_we_i      (core_we),
    .core_addr_i    (core_addr),
    .core_wdata_i   (core_wdata),
    .core_gnt_o     (core_gnt),
    .core_rvalid_o  (core_rv),
    .core_rdata_o   (core_rd),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .fetch_enable_o (fe_o),
    .state_o        (st_o),
    .timeout_o      (to_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input bit keep_pend);
    m_state = LOAD; m_rr_core = 0; m_spi_rv = 0; m_core_rv = 0; m_to = 0; m_idle = 0;
    m_spi_rd = 0; m_core_rd = 0;
    m_own.delete();
    if (!keep_pend) pend.delete();
  endtask

  task automatic do_reset(input bit keep_pend);
    rst = 1; spi_req = 1; spi_we = 0; core_req = 1; core_we = 0; mem_gnt = 1; mem_rvalid = 0;
    #2;
    chk("rst_spi_gnt", 32'(spi_gnt), 0);
    chk("rst_core_gnt", 32'(core_gnt), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_spi_rv", 32'(spi_rv), 0);
    chk("rst_core_rv", 32'(core_rv), 0);
    chk("rst_spi_rd", spi_rd, 0);
    chk("rst_core_rd", core_rd, 0);
    chk("rst_fe", 32'(fe_o), 0);
    chk("rst_to", 32'(to_o), 0);
    chk("rst_state", 32'(st_o), 32'(LOAD));
    @(posedge clk); @(posedge clk); #1;
    rst = 0; spi_req = 0; core_req = 0; fe = 0;
    model_reset(keep_pend);
  endtask

  // One clock cycle: drive memory response, check everything mid-cycle, advance the model.
  task automatic tick();
    int sz, win, g, ncore;
    bit spi_ok, core_ok, w_we;
    logic [31:0] w_addr, w_wdata;
    mem_rvalid = 0;
    if (rv_mode == 1) mem_rvalid = pend.size() > 0;
    if (rv_mode == 2) mem_rvalid = (pend.size() > 0) && ($urandom % 2 == 1);
    mem_rdata = mem_rvalid ? pend[0] : $urandom;
    @(negedge clk);
    s_spi_gnt = spi_gnt; s_core_gnt = core_gnt; s_state = st_o; s_fe = fe_o; s_to = to_o;
    s_spi_rv = spi_rv; s_core_rv = core_rv; s_spi_rd = spi_rd; s_core_rd = core_rd;
    sz = m_own.size();
    spi_ok  = spi_req && (spi_we || sz < 2);
    core_ok = core_req && (m_state == RUN) && (core_we || sz < 2);
    win = 0;
    if (spi_ok && core_ok) win = m_rr_core ? 2 : 1;
    else if (spi_ok)       win = 1;
    else if (core_ok)      win = 2;
    w_we    = (win == 2) ? core_we : spi_we;
    w_addr  = (win == 2) ? core_addr : spi_addr;
    w_wdata = (win == 2) ? core_wdata : spi_wdata;
    chk("mem_req", 32'(mem_req), 32'(win != 0));
    chk("spi_gnt", 32'(spi_gnt), 32'(win == 1 && mem_gnt));
    chk("core_gnt", 32'(core_gnt), 32'(win == 2 && mem_gnt));
    if (win != 0) begin
      chk("mem_we", 32'(mem_we), 32'(w_we));
      chk("mem_addr", mem_addr, w_addr);
      if (w_we) chk("mem_wdata", mem_wdata, w_wdata);
    end
    chk("spi_rvalid", 32'(spi_rv), 32'(m_spi_rv));
    chk("core_rvalid", 32'(core_rv), 32'(m_core_rv));
    chk("spi_rdata", spi_rd, m_spi_rd);
    chk("core_rdata", core_rd, m_core_rd);
    chk("state", 32'(st_o), 32'(m_state));
    chk("fetch_en", 32'(fe_o), 32'(m_state == RUN));
    chk("timeout", 32'(to_o), 32'(m_to));
    g = mem_gnt ? win : 0;
    ncore = 0;
    foreach (m_own[i]) if (m_own[i]) ncore++;
    m_spi_rv = 0; m_core_rv = 0;
    if (mem_rvalid) begin
      if (sz > 0) begin
        if (m_own.pop_front()) begin m_core_rv = 1; m_core_rd = mem_rdata; end
        else                   begin m_spi_rv = 1;  m_spi_rd = mem_rdata;  end
      end
      void'(pend.pop_front());
    end
    if (g != 0) begin
      if (w_we) mem_arr[w_addr[7:2]] = w_wdata;
      else begin
        m_own.push_back(g == 2);
        pend.push_back(mem_arr[w_addr[7:2]]);
      end
      m_rr_core = (g == 1);
    end
    case (m_state)
      LOAD: begin
        if (g == 1 && spi_we && spi_wdata == END) m_state = ARMED;
`ifdef BOOT_TIMEOUT_EN
        else if (g == 1) m_idle = 0;
        else if (m_idle == TO - 1) begin m_state = ARMED; m_to = 1; end
        else m_idle++;
`endif
      end
      ARMED: if (fe) m_state = RUN;
      RUN:   if (!fe) m_state = DRAIN;
      DRAIN: if (ncore == 0) m_state = ARMED;
      default: m_state = LOAD;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic boot_to_run();
    bit done = 0;
    do_reset(0);
    mem_gnt = 1; spi_req = 1; spi_we = 1; spi_addr = 32'h90; spi_wdata = END;
    for (int i = 0; i < 6 && !done; i++) begin tick(); done = s_spi_gnt; end
    spi_req = 0; fe = 1; done = 0;
    for (int i = 0; i < 6 && !done; i++) begin tick(); done = (s_state == RUN); end
    chk("boot_to_run", 32'(s_state), 32'(RUN));
  endtask

  typedef struct {
    bit          spi_req, spi_we;
    logic [31:0] spi_addr, spi_wdata;
    bit          core_req, core_we;
    logic [31:0] core_addr;
    bit          fe, e_spi_gnt, e_core_gnt;
    state_e      e_state;
    bit          e_fe;
  } vec_t;

  vec_t tbl[10];

  initial begin #2_000_000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

  initial begin
    int cnt, prev;
    bit done;
    tbl[0] = '{1, 1, 32'h80, 32'h11, 1, 0, 32'h80, 0, 1, 0, LOAD, 0};
    tbl[1] = '{1, 1, 32'h84, 32'h22, 1, 0, 32'h80, 0, 1, 0, LOAD, 0};
    tbl[2] = '{1, 1, 32'h88, 32'h33, 1, 0, 32'h80, 0, 1, 0, LOAD, 0};
    tbl[3] = '{1, 1, 32'h8C, 32'h44, 1, 0, 32'h80, 0, 1, 0, LOAD, 0};
    tbl[4] = '{1, 1, 32'h90, END,    1, 0, 32'h80, 1, 1, 0, LOAD, 0};
    tbl[5] = '{0, 0, 32'h0,  32'h0,  1, 0, 32'h80, 1, 0, 0, ARMED, 0};
    tbl[6] = '{0, 0, 32'h0,  32'h0,  1, 0, 32'h80, 1, 0, 1, RUN, 1};
    tbl[7] = '{0, 0, 32'h0,  32'h0,  0, 0, 32'h80, 0, 0, 0, RUN, 1};
    tbl[8] = '{0, 0, 32'h0,  32'h0,  0, 0, 32'h80, 0, 0, 0, DRAIN, 0};
    tbl[9] = '{0, 0, 32'h0,  32'h0,  0, 0, 32'h80, 0, 0, 0, ARMED, 0};
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;

    // Boot sequence: four loads, END_WORD, arm, run, drain.
    do_reset(0);
    rv_mode = 1; mem_gnt = 1;
    for (int i = 0; i < 10; i++) begin
      spi_req = tbl[i].spi_req; spi_we = tbl[i].spi_we;
      spi_addr = tbl[i].spi_addr; spi_wdata = tbl[i].spi_wdata;
      core_req = tbl[i].core_req; core_we = tbl[i].core_we; core_addr = tbl[i].core_addr;
      fe = tbl[i].fe;
      tick();
      chk($sformatf("tbl%0d_spi_gnt", i), 32'(s_spi_gnt), 32'(tbl[i].e_spi_gnt));
      chk($sformatf("tbl%0d_core_gnt", i), 32'(s_core_gnt), 32'(tbl[i].e_core_gnt));
      chk($sformatf("tbl%0d_state", i), 32'(s_state), 32'(tbl[i].e_state));
      chk($sformatf("tbl%0d_fe", i), 32'(s_fe), 32'(tbl[i].e_fe));
    end
    spi_req = 0; core_req = 0;

    // Core is locked out while loading.
    do_reset(0);
    mem_gnt = 1; core_req = 1; core_we = 0; core_addr = 32'h40; cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(s_core_gnt); end
    chk("load_core_gnts", cnt, 0);
    core_req = 0;

    // Idle load: timeout arms the core, or without the feature stays loading.
    do_reset(0);
`ifdef BOOT_TIMEOUT_EN
    for (int i = 0; i <= TO; i++) begin
      tick();
      if (i == TO - 1) chk("to_before", {s_to, 29'd0, 2'(s_state)}, {1'b0, 29'd0, 2'(LOAD)});
      if (i == TO)     chk("to_hit", {s_to, 29'd0, 2'(s_state)}, {1'b1, 29'd0, 2'(ARMED)});
    end
`else
    for (int i = 0; i < 30; i++) tick();
    chk("no_to_state", 32'(s_state), 32'(LOAD));
    chk("no_to_flag", 32'(s_to), 0);
`endif

    // Both ports read together: grants alternate, data routed by owner.
    boot_to_run();
    rv_mode = 1; mem_arr[16] = 32'hA5A5_0016; mem_arr[32] = 32'h5A5A_0032;
    spi_req = 1; spi_we = 0; spi_addr = 32'h40;
    core_req = 1; core_we = 0; core_addr = 32'h80;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_spi_gnt || s_core_gnt) begin
        if (prev >= 0) chk("rr_alternate", 32'(s_core_gnt), 32'(prev == 0));
        prev = int'(s_core_gnt);
      end
    end
    chk("rr_spi_rdata", s_spi_rd, 32'hA5A5_0016);
    chk("rr_core_rdata", s_core_rd, 32'h5A5A_0032);
    spi_req = 0; core_req = 0;
    for (int i = 0; i < 3; i++) tick();

    // Third back-to-back core read stalls on a full owner FIFO.
    rv_mode = 0; core_req = 1; core_we = 0; core_addr = 32'h100; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_core_gnt) begin cnt++; core_addr = core_addr + 4; end
    end
    chk("fifo_full_stall", cnt, 2);
    rv_mode = 1;
    for (int i = 0; i < 4 && cnt < 3; i++) begin
      tick();
      if (s_core_gnt) cnt++;
    end
    chk("fifo_resume", cnt, 3);
    core_req = 0;
    for (int i = 0; i < 4; i++) tick();

    // Drop fetch enable with two reads in flight: drain until both return.
    rv_mode = 0; core_req = 1; core_addr = 32'h20; cnt = 0;
    for (int i = 0; i < 6 && cnt < 2; i++) begin tick(); cnt += int'(s_core_gnt); end
    core_req = 0; fe = 0;
    tick(); tick();
    chk("drain_state", 32'(s_state), 32'(DRAIN));
    chk("drain_fe", 32'(s_fe), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("drain_hold", 32'(s_state), 32'(DRAIN));
    rv_mode = 1; done = 0;
    for (int i = 0; i < 6 && !done; i++) begin tick(); done = (s_state == ARMED); end
    chk("drain_to_armed", 32'(s_state), 32'(ARMED));

    // Reset with a read in flight: the late rvalid must be dropped.
    boot_to_run();
    rv_mode = 0; core_req = 1; core_we = 0; core_addr = 32'h60; done = 0;
    for (int i = 0; i < 4 && !done; i++) begin tick(); done = s_core_gnt; end
    core_req = 0;
    do_reset(1);
    rv_mode = 1;
    tick(); tick();
    chk("stale_rvalid", {30'd0, s_spi_rv, s_core_rv}, 0);

    // Random traffic against the model.
    do_reset(0);
    rv_mode = 2;
    for (int n = 0; n < 2000; n++) begin
      if (!(spi_req && !s_spi_gnt)) begin
        spi_req = ($urandom % 3) != 0; spi_we = $urandom % 2;
        spi_addr = {24'd0, 6'($urandom), 2'b00};
        spi_wdata = ($urandom % 5 == 0) ? END : $urandom;
      end
      if (!(core_req && !s_core_gnt)) begin
        core_req = ($urandom % 3) != 0; core_we = $urandom % 2;
        core_addr = {24'd0, 6'($urandom), 2'b00}; core_wdata = $urandom;
      end
      if ($urandom % 20 == 0) fe = ~fe;
      mem_gnt = ($urandom % 4) != 0;
      tick();
      if (n == 0) begin s_spi_gnt = 0; s_core_gnt = 0; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
